wshb_frame_reader: RTL and testbench

//   Wishbone master that reads the framebuffer the video stream writer deposits in SDRAM.

---
 rtl/video_pkg.sv | 26 ++
 rtl/wshb_frame_reader.sv | 139 +++++++++++++
 tb/tb_wshb_frame_reader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: display defaults, Wishbone cycle-type codes and
// the frame reader's state encoding and registered bus-request payload.
package video_pkg;

  localparam int unsigned HDISP_DEF     = 800;
  localparam int unsigned VDISP_DEF     = 480;
  localparam int unsigned BURST_LEN_DEF = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } frd_state_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [2:0]  cti;
  } wb_req_t;

endpackage

// File: rtl/wshb_frame_reader.sv
// Wishbone burst-read master streaming a raster framebuffer from SDRAM into a
// downstream pixel FIFO, one registered push per acknowledged beat.
module wshb_frame_reader
  import video_pkg::*;
#(
  parameter int unsigned HDISP     = HDISP_DEF,
  parameter int unsigned VDISP     = VDISP_DEF,
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic        frame_sync,
  output logic        wshb_cyc_o,
  output logic        wshb_stb_o,
  output logic        wshb_we_o,
  output logic [31:0] wshb_adr_o,
  output logic [3:0]  wshb_sel_o,
  output logic [2:0]  wshb_cti_o,
  output logic [1:0]  wshb_bte_o,
  input  logic [31:0] wshb_dat_i,
  input  logic        wshb_ack_i,
  input  logic        wshb_err_i,
  input  logic        wshb_rty_i,
  input  logic        fifo_walmost_full,
  output logic        fifo_write,
  output logic [31:0] fifo_wdata,
  output logic        frame_done,
  output logic        bus_error
);

  localparam int unsigned NPIX   = HDISP * VDISP;
  localparam int unsigned PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NPIX - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  frd_state_t        state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              sync_pend_q, sync_pend_d;
  wb_req_t           req_q, req_d;
  logic              fifo_write_d, frame_done_d, bus_error_d;
  logic [31:0]       fifo_wdata_d;
  logic              term;

  // State register plus output register stage
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      beat_q      <= '0;
      sync_pend_q <= 1'b0;
      req_q       <= '0;
      fifo_write  <= 1'b0;
      fifo_wdata  <= '0;
      frame_done  <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      beat_q      <= beat_d;
      sync_pend_q <= sync_pend_d;
      req_q       <= req_d;
      fifo_write  <= fifo_write_d;
      fifo_wdata  <= fifo_wdata_d;
      frame_done  <= frame_done_d;
      bus_error   <= bus_error_d;
    end
  end

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    beat_d       = beat_q;
    sync_pend_d  = sync_pend_q;
    fifo_write_d = 1'b0;
    fifo_wdata_d = fifo_wdata;
    frame_done_d = 1'b0;
    bus_error_d  = bus_error;
    req_d        = '0;
    term         = wshb_err_i | wshb_rty_i;

    unique case (state_q)
      IDLE: begin
        if (frame_sync) pix_d = '0;
        if (enable && !fifo_walmost_full) state_d = BURST;
      end
      BURST: begin
        if (term) begin
          // Terminated beat is not pushed; the next burst retries this pixel
          bus_error_d = bus_error | wshb_err_i;
          beat_d      = '0;
          state_d     = GAP;
        end else if (wshb_ack_i) begin
          fifo_write_d = 1'b1;
          fifo_wdata_d = wshb_dat_i;
          frame_done_d = (pix_q == LAST_PIX);
          pix_d        = (pix_q == LAST_PIX) ? '0 : pix_q + PIX_W'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = GAP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        // A sync seen during a burst takes effect as the burst ends
        if (state_d == GAP) begin
          if (frame_sync || sync_pend_q) pix_d = '0;
          sync_pend_d = 1'b0;
        end else if (frame_sync) begin
          sync_pend_d = 1'b1;
        end
      end
      GAP: begin
        if (frame_sync) pix_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_d.cyc = (state_d == BURST);
    req_d.stb = (state_d == BURST);
    req_d.adr = BASE_ADDR + (32'(pix_d) << 2);
    if (state_d == BURST) req_d.cti = (beat_d == LAST_BEAT) ? CTI_EOB : CTI_INCR;
    else                  req_d.cti = CTI_CLASSIC;
  end

  assign wshb_cyc_o = req_q.cyc;
  assign wshb_stb_o = req_q.stb;
  assign wshb_adr_o = req_q.adr;
  assign wshb_cti_o = req_q.cti;
  assign wshb_we_o  = 1'b0;
  assign wshb_sel_o = 4'hF;
  assign wshb_bte_o = 2'b00;

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Directed bench for wshb_frame_reader on an 8x2 frame with 4-beat bursts,
// driving an SDRAM slave model and checking a pixel FIFO model.
module tb_wshb_frame_reader;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        enable, frame_sync, fifo_walmost_full;
  logic        wshb_cyc_o, wshb_stb_o, wshb_we_o;
  logic [31:0] wshb_adr_o, wshb_dat_i;
  logic [3:0]  wshb_sel_o;
  logic [2:0]  wshb_cti_o;
  logic [1:0]  wshb_bte_o;
  logic        wshb_ack_i, wshb_err_i, wshb_rty_i;
  logic        fifo_write, frame_done, bus_error;
  logic [31:0] fifo_wdata;

  always #5 sys_clk = ~sys_clk;

  wshb_frame_reader #(
    .HDISP(8), .VDISP(2), .BASE_ADDR(32'd0), .BURST_LEN(4)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .frame_sync(frame_sync),
    .wshb_cyc_o(wshb_cyc_o), .wshb_stb_o(wshb_stb_o), .wshb_we_o(wshb_we_o),
    .wshb_adr_o(wshb_adr_o), .wshb_sel_o(wshb_sel_o), .wshb_cti_o(wshb_cti_o),
    .wshb_bte_o(wshb_bte_o), .wshb_dat_i(wshb_dat_i), .wshb_ack_i(wshb_ack_i),
    .wshb_err_i(wshb_err_i), .wshb_rty_i(wshb_rty_i),
    .fifo_walmost_full(fifo_walmost_full), .fifo_write(fifo_write),
    .fifo_wdata(fifo_wdata), .frame_done(frame_done), .bus_error(bus_error)
  );

  int n_pass   = 0;
  int n_checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // SDRAM slave model with optional wait states and an error at one address
  logic        hit;
  logic        err_arm = 1'b0;
  logic [31:0] err_adr = 32'd0;
  int          max_wait = 0;
  logic [2:0]  wcnt = 3'd0;

  assign hit        = wshb_cyc_o & wshb_stb_o;
  assign wshb_err_i = hit & err_arm & (wshb_adr_o == err_adr);
  assign wshb_rty_i = 1'b0;
  assign wshb_ack_i = hit & (wcnt == 3'd0) & ~wshb_err_i;
  assign wshb_dat_i = hit ? mem_word(wshb_adr_o >> 2) : 32'h0;

  always @(posedge sys_clk) begin
    if (wshb_ack_i || wshb_err_i) wcnt <= 3'($urandom_range(32'(max_wait), 0));
    else if (hit && wcnt != 3'd0) wcnt <= wcnt - 3'd1;
  end

  // FIFO model: every ack must be pushed one cycle later with its data
  logic        mon_en = 1'b0, ord_en = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_dat = 32'd0, prev_adr = 32'd0;
  int          exp_pix = 0, fd_count = 0, push_count = 0;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      check("fifo_write", 32'(fifo_write), 32'(prev_ack));
      if (prev_ack) check("fifo_wdata", fifo_wdata, prev_dat);
      check("frame_done", 32'(frame_done), 32'(prev_ack && prev_adr == 32'd60));
      if (fifo_write) begin
        push_count++;
        if (ord_en) begin
          check("order", fifo_wdata, mem_word(32'(exp_pix)));
          exp_pix = (exp_pix + 1) % 16;
        end
      end
      if (frame_done) fd_count++;
    end
    prev_ack = wshb_ack_i;
    prev_dat = wshb_dat_i;
    prev_adr = wshb_adr_o;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_cyc(input string tag);
    int n;
    n = 0;
    while (wshb_cyc_o !== 1'b1 && n < 200) begin tick(); n++; end
    check({tag, " cyc"}, 32'(wshb_cyc_o), 32'd1);
  endtask

  // Check beats k0..k1-1 of a burst starting at a0, leaving the bench just past the last one
  task automatic expect_burst(input logic [31:0] a0, input int k0, input int k1, input string tag);
    int n;
    wait_cyc(tag);
    for (int k = k0; k < k1; k++) begin
      n = 0;
      while (wshb_ack_i !== 1'b1 && n < 50) begin tick(); n++; end
      check($sformatf("%s ack%0d", tag, k), 32'(wshb_ack_i), 32'd1);
      check($sformatf("%s adr%0d", tag, k), wshb_adr_o, a0 + 32'(4 * k));
      check($sformatf("%s cti%0d", tag, k), 32'(wshb_cti_o), (k == 3) ? 32'd7 : 32'd2);
      tick();
    end
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    int n;
    sys_rst = 1'b1; enable = 1'b0; frame_sync = 1'b0; fifo_walmost_full = 1'b0;
    repeat (3) tick();
    check("rst cyc", 32'(wshb_cyc_o), 32'd0);
    check("rst stb", 32'(wshb_stb_o), 32'd0);
    check("rst adr", wshb_adr_o, 32'd0);
    check("rst cti", 32'(wshb_cti_o), 32'd0);
    check("rst we", 32'(wshb_we_o), 32'd0);
    check("rst sel", 32'(wshb_sel_o), 32'hF);
    check("rst bte", 32'(wshb_bte_o), 32'd0);
    check("rst fifo_write", 32'(fifo_write), 32'd0);
    check("rst fifo_wdata", fifo_wdata, 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst bus_error", 32'(bus_error), 32'd0);
    sys_rst = 1'b0; mon_en = 1'b1; ord_en = 1'b1; exp_pix = 0;
    tick();

    // 1: full frame with an always-ack slave
    enable = 1'b1;
    expect_burst(32'd0, 0, 4, "t1 b0");
    check("t1 gap cyc", 32'(wshb_cyc_o), 32'd0);
    tick();
    check("t1 idle cyc", 32'(wshb_cyc_o), 32'd0);
    tick();
    check("t1 next cyc", 32'(wshb_cyc_o), 32'd1);
    expect_burst(32'd16, 0, 4, "t1 b1");
    expect_burst(32'd32, 0, 4, "t1 b2");
    expect_burst(32'd48, 0, 4, "t1 b3");
    check("t1 frame_done", 32'(frame_done), 32'd1);
    check("t1 last word", fifo_wdata, mem_word(32'd15));
    expect_burst(32'd0, 0, 4, "t1 wrap");
    ord_en = 1'b0;

    // 2: almost-full mid-burst, then held in IDLE, then released
    tick(); tick();
    check("t2 start adr", wshb_adr_o, 32'd16);
    fifo_walmost_full = 1'b1;
    expect_burst(32'd16, 0, 4, "t2 mid");
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2 held%0d", i), 32'(wshb_cyc_o), 32'd0);
    end
    fifo_walmost_full = 1'b0;
    tick();
    check("t2 release cyc", 32'(wshb_cyc_o), 32'd1);
    expect_burst(32'd32, 0, 4, "t2 after");

    // frame_sync while idle restarts at pixel 0
    enable = 1'b0;
    repeat (4) begin tick(); check("idle cyc", 32'(wshb_cyc_o), 32'd0); end
    pulse_sync();
    enable = 1'b1;
    expect_burst(32'd0, 0, 4, "t4 idle sync");

    // 3: error on the third beat of the burst at 16
    err_adr = 32'd24; err_arm = 1'b1;
    expect_burst(32'd16, 0, 2, "t3 pre");
    check("t3 err adr", wshb_adr_o, 32'd24);
    tick();
    err_arm = 1'b0;
    check("t3 gap cyc", 32'(wshb_cyc_o), 32'd0);
    check("t3 bus_error", 32'(bus_error), 32'd1);
    expect_burst(32'd24, 0, 4, "t3 retry");
    enable = 1'b0;
    repeat (3) tick();
    check("t3 sticky", 32'(bus_error), 32'd1);

    // 4: frame_sync during the burst at 32 lets it complete first
    pulse_sync();
    enable = 1'b1;
    expect_burst(32'd0, 0, 4, "t4 b0");
    expect_burst(32'd16, 0, 4, "t4 b1");
    wait_cyc("t4 b2");
    tick();
    check("t4 beat1 adr", wshb_adr_o, 32'd36);
    pulse_sync();
    expect_burst(32'd32, 2, 4, "t4 tail");
    expect_burst(32'd0, 0, 4, "t4 restart");

    // 5: random wait states over three frames
    enable = 1'b0;
    repeat (3) tick();
    pulse_sync();
    exp_pix = 0; ord_en = 1'b1; fd_count = 0; push_count = 0; max_wait = 5;
    enable = 1'b1;
    n = 0;
    while (fd_count < 3 && n < 5000) begin tick(); n++; end
    enable = 1'b0;
    check("t5 frames", 32'(fd_count), 32'd3);
    check("t5 pushes", 32'(push_count), 32'd48);
    n = 0;
    while (wshb_cyc_o !== 1'b0 && n < 100) begin tick(); n++; end
    repeat (3) tick();
    check("t5 idle", 32'(wshb_cyc_o), 32'd0);
    max_wait = 0; ord_en = 1'b0;

    // 6: reset in the middle of a burst
    enable = 1'b1;
    n = 0;
    while (!(wshb_cyc_o === 1'b1 && wshb_adr_o === 32'd8) && n < 100) begin tick(); n++; end
    check("t6 reach", wshb_adr_o, 32'd8);
    mon_en = 1'b0;
    sys_rst = 1'b1;
    #1;
    check("t6 cyc", 32'(wshb_cyc_o), 32'd0);
    check("t6 stb", 32'(wshb_stb_o), 32'd0);
    check("t6 fifo_write", 32'(fifo_write), 32'd0);
    check("t6 bus_error", 32'(bus_error), 32'd0);
    tick();
    sys_rst = 1'b0;
    tick();
    mon_en = 1'b1;
    expect_burst(32'd0, 0, 4, "t6 restart");
    enable = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
